uart_tx: RTL

Serial transmitter that consumes the oversampling tick from the free-running baud counter (its `max_tick`, wired to `s_tick`) and shifts out one UART frame per request. It sits between the byte source (control/packet logic) and the FPGA TX pin. Frame format is LSB-first: start bit, data bits, optional parity bit, stop bit(s). Each bit is 16 ticks long.

---
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte-source to UART transmitter connection: oversample tick, start
// request and data toward the transmitter, status and serial line back.
//
// Handshake: the source raises tx_start with din valid. The transmitter
// accepts on the first clock edge where it is idle, meaning busy=0.
// There is no ready signal and no queue. A request made while busy=1 is
// ignored, so the source waits for busy=0 or tx_done_tick before it
// issues the next request.
interface uart_tx_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx_done_tick;
    logic            busy;
    logic            tx;

    modport master (
        output s_tick, tx_start, din,
        input  tx_done_tick, busy, tx
    );

    modport slave (
        input  s_tick, tx_start, din,
        output tx_done_tick, busy, tx
    );
endinterface

// File: rtl/uart_tx.sv
// UART frame transmitter. It sends an LSB-first frame made of a start bit,
// DBIT data bits, an optional parity bit and the stop bit(s). Each bit is
// paced by the 16x oversample tick. The serial line is registered, so it
// trails the FSM state by one clock.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PAR     = 0
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   tx_if,
    output logic [2:0] state_o
);
    // The tick counter must be wide enough for both 16-tick bits and long stop bits.
    localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int SW    = $clog2(S_MAX);

    localparam logic [SW-1:0] BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST    = 3'(DBIT - 1);
    // Parity modes outside 1 and 2 behave as no parity.
    localparam bit            PAR_EN    = (PAR == 1) || (PAR == 2);
    localparam bit            PAR_ODD   = (PAR == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic            tx_q, tx_d;
    logic            done;

    // State and datapath registers. Reset aborts any frame and returns the line to idle-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic, next line level, and the combinational done pulse on the final stop tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        tx_d    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_if.tx_start) begin
                    b_d     = tx_if.din;
                    p_d     = PAR_ODD;
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (tx_if.s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                tx_d = b_q[0];
                if (tx_if.s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        p_d = p_q ^ b_q[0];
                        b_d = {1'b0, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = PAR_EN ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                tx_d = p_q;
                if (tx_if.s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tx_if.s_tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = '0;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_if.tx           = tx_q;
    assign tx_if.busy         = (state_q != IDLE);
    assign tx_if.tx_done_tick = done;
    assign state_o            = state_q;
endmodule
